// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and RX FIFO.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;
    localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Byte storage for the RX FIFO: one synchronous write port, one asynchronous read port.
module fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [BYTE_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [BYTE_W-1:0]        o_rdata
);

    // Contents are never reset; validity is tracked by the pointers in the parent.
    logic [BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO with sticky overflow flag and stored-line tracking.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned       DEPTH    = 16,
    parameter logic [BYTE_W-1:0] EOL_CHAR = ASCII_LF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [BYTE_W-1:0]      i_rx_data,
    input  logic                   i_rx_valid,
    output logic [BYTE_W-1:0]      o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_overflow,
    input  logic                   i_clr_ovf,
    output logic                   o_line_ready
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   CW       = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     line_cnt_q, line_cnt_d;
    logic              ovf_q, ovf_d;
    logic [BYTE_W-1:0] head;
    logic              empty, full;
    logic              push, pop, drop, wr_en;
    logic              push_eol, pop_eol;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte.
    assign pop      = !empty && i_ready;
    assign push     = i_rx_valid && (!full || pop);
    assign drop     = i_rx_valid && !push;
    assign push_eol = push && (i_rx_data == EOL_CHAR);
    assign pop_eol  = pop && (head == EOL_CHAR);

    // The async reset holds the pointers, but storage must not be written either.
    assign wr_en = push && !i_rst;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        line_cnt_d = line_cnt_q;
        ovf_d      = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({push_eol, pop_eol})
            2'b10:   line_cnt_d = line_cnt_q + 1'b1;
            2'b01:   line_cnt_d = line_cnt_q - 1'b1;
            default: line_cnt_d = line_cnt_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            line_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            line_cnt_q <= line_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_rx_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (head)
    );

    assign o_data       = head;
    assign o_valid      = !empty;
    assign o_count      = count_q;
    assign o_full       = full;
    assign o_overflow   = ovf_q;
    assign o_line_ready = (line_cnt_q != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH 16, EOL 0x0A).
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] o_data;
    logic       o_valid;
    logic       ready;
    logic [4:0] o_count;
    logic       o_full;
    logic       o_overflow;
    logic       clr_ovf;
    logic       o_line_ready;

    int n_checks;
    int n_fail;

    int         sent;
    int         got;
    logic       dp;
    logic       dr;
    logic       acc;
    logic [7:0] b;
    logic [7:0] q[$];

    uart_rx_fifo #(
        .DEPTH    (16),
        .EOL_CHAR (8'h0A)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (ready),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_overflow   (o_overflow),
        .i_clr_ovf    (clr_ovf),
        .o_line_ready (o_line_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        rx_data  = v;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, o_data, exp);
        chk({tag, "_v"}, o_valid, 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        ready    = 1'b0;
        clr_ovf  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_line", o_line_ready, 0);
        rst = 1'b0;

        // Three consecutive pushes, no consumer.
        push_byte(8'h41);
        chk("abc_valid1", o_valid, 1);
        chk("abc_data1", o_data, 8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        chk("abc_count", o_count, 3);
        chk("abc_data", o_data, 8'h41);
        chk("abc_valid", o_valid, 1);
        chk("abc_line", o_line_ready, 0);
        pop_chk("abc_pop0", 8'h41);
        pop_chk("abc_pop1", 8'h42);
        pop_chk("abc_pop2", 8'h43);
        chk("abc_empty", o_valid, 0);

        // Fill to full, then overflow.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", o_full, 1);
        chk("fill_count", o_count, 16);
        chk("fill_ovf", o_overflow, 0);
        chk("fill_line", o_line_ready, 1);
        push_byte(8'hAA);
        chk("ovf_set", o_overflow, 1);
        chk("ovf_full", o_full, 1);
        chk("ovf_count", o_count, 16);
        for (int i = 0; i < 16; i++) pop_chk("drain", 8'(i));
        chk("drain_empty", o_valid, 0);
        chk("drain_line", o_line_ready, 0);
        chk("ovf_sticky", o_overflow, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr", o_overflow, 0);

        // Set wins over clear when both happen together.
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        clr_ovf  = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("setwin_ovf", o_overflow, 1);
        chk("setwin_count", o_count, 16);
        step();
        clr_ovf = 1'b0;
        chk("setwin_clr", o_overflow, 0);

        // Push and pop together while full.
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        ready    = 1'b1;
        chk("pp_head", o_data, 8'h10);
        step();
        rx_valid = 1'b0;
        ready    = 1'b0;
        chk("pp_count", o_count, 16);
        chk("pp_ovf", o_overflow, 0);
        chk("pp_full", o_full, 1);
        for (int i = 1; i < 16; i++) pop_chk("pp_drain", 8'h10 + 8'(i));
        pop_chk("pp_last", 8'h55);
        chk("pp_empty", o_count, 0);

        // Pop request while empty is ignored.
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("epop_count", o_count, 0);
        chk("epop_valid", o_valid, 0);
        push_byte(8'h77);
        chk("epop_data", o_data, 8'h77);
        chk("epop_cnt1", o_count, 1);
        pop_chk("epop_pop", 8'h77);

        // Line tracking.
        push_byte(8'h4F);
        push_byte(8'h4B);
        chk("ok_line0", o_line_ready, 0);
        push_byte(8'h0A);
        chk("ok_line1", o_line_ready, 1);
        pop_chk("ok_pop0", 8'h4F);
        pop_chk("ok_pop1", 8'h4B);
        chk("ok_line_held", o_line_ready, 1);
        pop_chk("ok_pop2", 8'h0A);
        chk("ok_line_clr", o_line_ready, 0);
        push_byte(8'h0A);
        chk("lf_line", o_line_ready, 1);
        rx_data  = 8'h0A;
        rx_valid = 1'b1;
        ready    = 1'b1;
        step();
        rx_valid = 1'b0;
        ready    = 1'b0;
        chk("lfpp_line", o_line_ready, 1);
        chk("lfpp_count", o_count, 1);
        pop_chk("lfpp_pop", 8'h0A);
        chk("lfpp_line0", o_line_ready, 0);

        // A dropped EOL byte must not count as a line.
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        push_byte(8'h0A);
        chk("dropeol_line", o_line_ready, 0);
        chk("dropeol_ovf", o_overflow, 1);
        for (int i = 0; i < 16; i++) pop_chk("dropeol_drain", 8'h20 + 8'(i));
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        // Random-gap streaming against a queue scoreboard, crossing the pointer wrap.
        sent = 0;
        got  = 0;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (sent == 40 && q.size() == 0) break;
            dp = (sent < 40) && ($urandom_range(0, 2) != 0);
            dr = ($urandom_range(0, 2) != 0);
            b  = 8'($urandom_range(0, 255));
            rx_valid = dp;
            rx_data  = b;
            ready    = dr;
            chk("rand_count", o_count, q.size());
            chk("rand_cnt_max", (o_count <= 5'd16), 1);
            if (dr && q.size() != 0) chk("rand_data", o_data, q[0]);
            acc = dp && (q.size() < 16 || (dr && q.size() != 0));
            step();
            if (dr && q.size() != 0) begin
                void'(q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(b);
                sent++;
            end
        end
        rx_valid = 1'b0;
        ready    = 1'b0;
        chk("rand_done", got, 40);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        // Asynchronous reset between clock edges with data stored.
        for (int i = 0; i < 5; i++) push_byte(8'hB0 + 8'(i));
        chk("mrst_pre", o_count, 5);
        #3;
        rst = 1'b1;
        #1;
        chk("mrst_valid", o_valid, 0);
        chk("mrst_count", o_count, 0);
        chk("mrst_line", o_line_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_after", o_count, 0);
        push_byte(8'hC3);
        chk("mrst_data", o_data, 8'hC3);
        chk("mrst_cnt1", o_count, 1);
        pop_chk("mrst_pop", 8'hC3);
        chk("mrst_empty", o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; SHALL be a power of two, >= 2.
REQ-002 Parameter EOL_CHAR, default 8'h0A, byte value that terminates a line.
REQ-003 i_clk  input  1  sole clock; all state SHALL change on its rising edge except on reset.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_rx_data  input  8  received byte from the UART receiver.
REQ-006 i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid when high.
REQ-007 o_data  output  8  head-of-FIFO byte, first-word fall-through.
REQ-008 o_valid  output  1  high when FIFO is non-empty.
REQ-009 i_ready  input  1  consumer pop request; a pop occurs when o_valid && i_ready.
REQ-010 o_count  output  $clog2(DEPTH)+1  bytes currently stored, 0..DEPTH.
REQ-011 o_full  output  1  o_count == DEPTH.
REQ-012 o_overflow  output  1  sticky, a byte was dropped.
REQ-013 i_clr_ovf  input  1  synchronous clear of o_overflow.
REQ-014 o_line_ready  output  1  at least one EOL_CHAR byte is stored.

Function
REQ-015 Push SHALL occur when i_rx_valid && (!o_full || pop this cycle). The byte is written at the write pointer, and the write pointer advances.
REQ-016 Push latency: a byte strobed at edge N SHALL make o_valid high and appear on o_data after edge N. No same-cycle bypass.
REQ-017 Pop SHALL advance the read pointer. o_data SHALL show the next byte in the following cycle without a bubble.
REQ-018 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 Push and pop in the same cycle SHALL leave o_count unchanged, including when full.
REQ-020 i_rx_valid while full with no pop SHALL drop the byte, leave contents unchanged, and set o_overflow at the next edge.
REQ-021 i_ready while empty SHALL be ignored and SHALL change no pointer or count.
REQ-022 o_overflow set and i_clr_ovf in the same cycle: set SHALL win.
REQ-023 Internal line counter (width $clog2(DEPTH)+1):
  - increments on an accepted push of EOL_CHAR;
  - decrements on a pop of EOL_CHAR;
  - unchanged when both occur in the same cycle.
  o_line_ready = (line counter != 0).
REQ-024 A dropped EOL_CHAR byte SHALL NOT increment the line counter.
REQ-025 o_full and o_line_ready SHALL be registered state or pure decodes of registered state. No input-to-output combinational path other than none; o_valid SHALL NOT depend on i_ready.
REQ-026 o_data SHALL be undefined-but-stable while o_valid is low. Consumers SHALL NOT sample it then.

Reset
REQ-027 i_rst assertion SHALL immediately clear both pointers, o_count, the line counter, and o_overflow. Outputs are then o_valid=0, o_full=0, o_overflow=0, o_line_ready=0, o_count=0.
REQ-028 Storage array SHALL NOT be reset; its contents are discarded logically by the pointer reset.
REQ-029 Reset mid-operation SHALL discard all stored bytes. No push or pop SHALL occur in a cycle where i_rst is high.
REQ-030 i_rst deassertion SHALL be synchronised to i_clk upstream of this block. The first push is permitted on the first edge after deassertion.

Structure
REQ-031 Shared header uart_pkg.vh SHALL hold:
  - BYTE_W = 8;
  - ASCII_LF = 8'h0A;
  - ASCII_CR = 8'h0D.
  The UART receiver, transmitter and this block SHALL use it.
REQ-032 Storage SHALL be one sub-module, fifo_mem: DEPTH x BYTE_W array, one synchronous write port, one asynchronous read port.
REQ-033 Pointer, count and line-counter control SHALL reside in uart_rx_fifo. No further sub-modules.

Verification
REQ-034 Reset, then push 0x41, 0x42, 0x43 on consecutive cycles with i_ready=0 -> o_count=3, o_data=0x41, o_valid=1, o_line_ready=0.
REQ-035 Fill 16 bytes 0x00..0x0F, then push 0xAA -> o_full=1, o_overflow=1, o_count=16. Drain all 16 -> bytes 0x00..0x0F in order; 0xAA never appears.
REQ-036 With 16 stored and i_ready=1, push 0x55 in the same cycle -> o_count stays 16, o_overflow stays 0, 0x55 is popped last.
REQ-037 Push "OK\n" (0x4F, 0x4B, 0x0A) -> o_line_ready=1 after the third push edge. Pop 3 -> o_line_ready=0. Push 0x0A while popping 0x0A -> o_line_ready unchanged.
REQ-038 Run 40 push/pop pairs across the pointer wrap with random gaps -> output sequence equals input sequence and o_count never exceeds 16.
REQ-039 Assert i_rst for 3 ns mid-stream with 5 bytes stored, off a clock edge -> o_valid=0 and o_count=0 before the next edge. The next push is read back correctly.
